// File: rtl/laser_pkg.sv
// Shared widths, colours and engine state encoding for the tower laser datapath.
package laser_pkg;
    localparam int X_W = 8;    // screen x, 0..159
    localparam int Y_W = 7;    // screen y, 0..119
    localparam int C_W = 3;    // VGA colour
    localparam int D_W = 9;    // |dx|, |dy| of a line
    localparam int E_W = 10;   // signed Bresenham error term

    localparam logic [C_W-1:0] COLOUR_BLACK = 3'b000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_ERASE = 2'd2,
        S_DONE  = 2'd3
    } eng_state_t;

    // Unsigned distance between two screen coordinates (y is zero-extended by the caller).
    function automatic logic [D_W-1:0] abs_diff(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
        return (a >= b) ? D_W'(a - b) : D_W'(b - a);
    endfunction
endpackage

// File: rtl/line_stepper.sv
// Bresenham line core: load latches both endpoints, each step advances one pixel.
// busy_o stays high while x_o/y_o hold a pixel that has not been consumed yet;
// stepping off the endpoint drops busy_o.
module line_stepper
    import laser_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [X_W-1:0] x0_i,
    input  logic [Y_W-1:0] y0_i,
    input  logic [X_W-1:0] x1_i,
    input  logic [Y_W-1:0] y1_i,
    output logic [X_W-1:0] x_o,
    output logic [Y_W-1:0] y_o,
    output logic           busy_o
);
    logic [X_W-1:0]        x_q, x1_q;
    logic [Y_W-1:0]        y_q, y1_q;
    logic [D_W-1:0]        dx_q, dy_q;
    logic                  sx_q, sy_q, busy_q;
    logic signed [E_W-1:0] err_q;

    logic [D_W-1:0]        ld_dx, ld_dy;
    logic signed [E_W-1:0] ld_err;
    logic signed [E_W:0]   e2, pdx, pdy, ndy, err_d;
    logic                  mv_x, mv_y, last;

    // Load-time deltas and per-step error update.
    always_comb begin
        ld_dx  = abs_diff(x1_i, x0_i);
        ld_dy  = abs_diff({1'b0, y1_i}, {1'b0, y0_i});
        ld_err = $signed({1'b0, ld_dx}) - $signed({1'b0, ld_dy});
        e2     = {err_q, 1'b0};
        pdx    = {2'b00, dx_q};
        pdy    = {2'b00, dy_q};
        ndy    = -pdy;
        mv_x   = e2 > ndy;
        mv_y   = e2 < pdx;
        err_d  = {err_q[E_W-1], err_q};
        if (mv_x) err_d = err_d - pdy;
        if (mv_y) err_d = err_d + pdx;
        last   = (x_q == x1_q) && (y_q == y1_q);
    end

    // Line state: load has priority over step.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            x_q <= '0; y_q <= '0; x1_q <= '0; y1_q <= '0;
            dx_q <= '0; dy_q <= '0; sx_q <= 1'b0; sy_q <= 1'b0;
            err_q <= '0; busy_q <= 1'b0;
        end else if (load_i) begin
            x_q    <= x0_i;
            y_q    <= y0_i;
            x1_q   <= x1_i;
            y1_q   <= y1_i;
            dx_q   <= ld_dx;
            dy_q   <= ld_dy;
            sx_q   <= (x1_i >= x0_i);
            sy_q   <= (y1_i >= y0_i);
            err_q  <= ld_err;
            busy_q <= 1'b1;
        end else if (step_i && busy_q) begin
            if (last) begin
                busy_q <= 1'b0;
            end else begin
                if (mv_x) x_q <= sx_q ? x_q + 1'b1 : x_q - 1'b1;
                if (mv_y) y_q <= sy_q ? y_q + 1'b1 : y_q - 1'b1;
                err_q <= err_d[E_W-1:0];
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign busy_o = busy_q;
endmodule

// File: rtl/datapath_laser.sv
// Tower laser datapath: range check, laser line draw/erase via a shared
// Bresenham stepper, and the post-erase delay timer.
// Optional: define LASER_DAMAGE_EN to add damage_pulse and a saturating hit_count.
module datapath_laser
    import laser_pkg::*;
#(
    parameter int              RANGE        = 20,
    parameter int              DELAY_CYCLES = 2500000,
    parameter logic [C_W-1:0]  LASER_COLOUR = 3'b100
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           disabled,
    input  logic           wait_draw,
    input  logic           draw_laser,
    input  logic           erase,
    input  logic           delay,
    input  logic [X_W-1:0] tower_x,
    input  logic [Y_W-1:0] tower_y,
    input  logic [X_W-1:0] car_x,
    input  logic [Y_W-1:0] car_y,
    input  logic           car_valid,
    output logic           car_in_range,
    output logic           draw_done,
    output logic           drawn,
    output logic           erase_done,
    output logic           delay_done,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           vga_plot
`ifdef LASER_DAMAGE_EN
    ,
    output logic           damage_pulse,
    output logic [7:0]     hit_count
`endif
);
    localparam int             CNT_W   = $clog2(DELAY_CYCLES + 1);
    localparam logic [D_W-1:0] RANGE_D = D_W'(RANGE);

    eng_state_t     state_q;
    logic           car_in_range_q, draw_done_q, erase_done_q, delay_done_q, drawn_q, vga_plot_q;
    logic [X_W-1:0] vga_x_q, ex0_q, ex1_q;
    logic [Y_W-1:0] vga_y_q, ey0_q, ey1_q;
    logic [C_W-1:0] vga_colour_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [D_W-1:0] rdx, rdy;
    logic           start_draw, start_erase, stp_step, stp_busy;
    logic [X_W-1:0] ld_x0, ld_x1, stp_x;
    logic [Y_W-1:0] ld_y0, ld_y1, stp_y;

    // wait_draw needs no datapath action: the engine idles whenever no command is up.
    logic unused_wait_draw;
    assign unused_wait_draw = wait_draw;

    // Range distances and engine handshakes with the stepper.
    always_comb begin
        rdx         = abs_diff(car_x, tower_x);
        rdy         = abs_diff({1'b0, car_y}, {1'b0, tower_y});
        start_draw  = (state_q == S_IDLE) && !disabled && !erase && draw_laser;
        start_erase = (state_q == S_IDLE) && !disabled && erase && drawn_q;
        stp_step    = !disabled && stp_busy &&
                      (((state_q == S_DRAW) && draw_laser && !erase) ||
                       ((state_q == S_ERASE) && erase));
        ld_x0       = start_erase ? ex0_q : tower_x;
        ld_y0       = start_erase ? ey0_q : tower_y;
        ld_x1       = start_erase ? ex1_q : car_x;
        ld_y1       = start_erase ? ey1_q : car_y;
    end

    line_stepper u_stepper (
        .clk    (clk),
        .resetn (resetn),
        .load_i (start_draw || start_erase),
        .step_i (stp_step),
        .x0_i   (ld_x0),
        .y0_i   (ld_y0),
        .x1_i   (ld_x1),
        .y1_i   (ld_y1),
        .x_o    (stp_x),
        .y_o    (stp_y),
        .busy_o (stp_busy)
    );

    // Registered Chebyshev range flag.
    always_ff @(posedge clk) begin
        if (!resetn) car_in_range_q <= 1'b0;
        else         car_in_range_q <= car_valid && (rdx <= RANGE_D) && (rdy <= RANGE_D);
    end

    // Draw/erase engine: one pixel per cycle, done pulse the cycle after the last pixel.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            drawn_q      <= 1'b0;
            draw_done_q  <= 1'b0;
            erase_done_q <= 1'b0;
            vga_plot_q   <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            ex0_q <= '0; ey0_q <= '0; ex1_q <= '0; ey1_q <= '0;
        end else begin
            draw_done_q  <= 1'b0;
            erase_done_q <= 1'b0;
            vga_plot_q   <= 1'b0;
            if (disabled) begin
                state_q <= S_IDLE;
                drawn_q <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (erase) begin
                            if (drawn_q) begin
                                state_q <= S_ERASE;
                            end else begin
                                erase_done_q <= 1'b1;
                                state_q      <= S_DONE;
                            end
                        end else if (draw_laser) begin
                            ex0_q   <= tower_x;
                            ey0_q   <= tower_y;
                            ex1_q   <= car_x;
                            ey1_q   <= car_y;
                            state_q <= S_DRAW;
                        end
                    end
                    S_DRAW: begin
                        // Dropped command aborts; a partial line stays marked as drawn.
                        if (!draw_laser || erase) begin
                            state_q <= S_IDLE;
                        end else if (stp_busy) begin
                            vga_plot_q   <= 1'b1;
                            vga_x_q      <= stp_x;
                            vga_y_q      <= stp_y;
                            vga_colour_q <= LASER_COLOUR;
                            drawn_q      <= 1'b1;
                        end else begin
                            draw_done_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                    S_ERASE: begin
                        if (!erase) begin
                            state_q <= S_IDLE;
                        end else if (stp_busy) begin
                            vga_plot_q   <= 1'b1;
                            vga_x_q      <= stp_x;
                            vga_y_q      <= stp_y;
                            vga_colour_q <= COLOUR_BLACK;
                        end else begin
                            erase_done_q <= 1'b1;
                            drawn_q      <= 1'b0;
                            state_q      <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        // Wait for the controller to release both commands before re-arming.
                        if (!draw_laser && !erase) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Delay counter: counts while delay is held, parks one past the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (disabled || !delay)                cnt_d = '0;
        else if (cnt_q != CNT_W'(DELAY_CYCLES)) cnt_d = cnt_q + 1'b1;
    end

    // Delay state and its single done pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q        <= '0;
            delay_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            delay_done_q <= !disabled && delay && (cnt_q == CNT_W'(DELAY_CYCLES - 1));
        end
    end

`ifdef LASER_DAMAGE_EN
    logic [7:0] hit_q;

    // Saturating count of completed laser lines.
    always_ff @(posedge clk) begin
        if (!resetn || disabled)               hit_q <= '0;
        else if (draw_done_q && hit_q != 8'hFF) hit_q <= hit_q + 1'b1;
    end

    assign damage_pulse = draw_done_q;
    assign hit_count    = hit_q;
`endif

    assign car_in_range = car_in_range_q;
    assign draw_done    = draw_done_q;
    assign erase_done   = erase_done_q;
    assign delay_done   = delay_done_q;
    assign drawn        = drawn_q;
    assign vga_x        = vga_x_q;
    assign vga_y        = vga_y_q;
    assign vga_colour   = vga_colour_q;
    assign vga_plot     = vga_plot_q;
endmodule

// File: tb/tb_datapath_laser.sv
// Bench for datapath_laser: range table plus random range checks, line draw/erase
// against a textbook Bresenham model, delay timer, abort, reset and disable cases.
module tb_datapath_laser;
    logic       clk = 1'b0, resetn = 1'b0, disabled = 1'b0, wait_draw = 1'b0;
    logic       draw_laser = 1'b0, erase = 1'b0, delay = 1'b0, car_valid = 1'b0;
    logic [7:0] tower_x = '0, car_x = '0;
    logic [6:0] tower_y = '0, car_y = '0;
    logic       car_in_range, draw_done, drawn, erase_done, delay_done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    datapath_laser #(.RANGE(20), .DELAY_CYCLES(4), .LASER_COLOUR(3'b100)) dut (
        .clk(clk), .resetn(resetn), .disabled(disabled), .wait_draw(wait_draw),
        .draw_laser(draw_laser), .erase(erase), .delay(delay),
        .tower_x(tower_x), .tower_y(tower_y), .car_x(car_x), .car_y(car_y),
        .car_valid(car_valid), .car_in_range(car_in_range), .draw_done(draw_done),
        .drawn(drawn), .erase_done(erase_done), .delay_done(delay_done),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    int nvec = 0, nbad = 0;

    typedef struct { int x; int y; int c; } pix_t;
    typedef struct { int tx; int ty; int cx; int cy; bit v; bit exp; } rvec_t;
    pix_t got_q[$];
    pix_t exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference line: textbook integer Bresenham from (x0,y0) to (x1,y1) inclusive.
    function automatic void model_line(input int x0, input int y0, input int x1, input int y1, input int c);
        int x = x0, y = y0, dx = iabs(x1 - x0), dy = iabs(y1 - y0);
        int sx = (x1 >= x0) ? 1 : -1, sy = (y1 >= y0) ? 1 : -1;
        int err = dx - dy, e2;
        pix_t p;
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            p.x = x; p.y = y; p.c = c;
            exp_q.push_back(p);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 > -dy) begin err -= dy; x += sx; end
            if (e2 < dx)  begin err += dx; y += sy; end
        end
    endfunction

    // Raise a command at a negedge, record plots until its done pulse or the budget runs out.
    task automatic run_cmd(input bit is_erase, input int budget, output int done_at, output int last_at);
        pix_t p;
        got_q.delete();
        done_at = -1; last_at = -1;
        if (is_erase) erase = 1'b1; else draw_laser = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (vga_plot) begin
                p.x = int'(vga_x); p.y = int'(vga_y); p.c = int'(vga_colour);
                got_q.push_back(p);
                last_at = i;
            end
            if (is_erase ? erase_done : draw_done) begin done_at = i; break; end
        end
        erase = 1'b0; draw_laser = 1'b0;
        @(negedge clk); @(negedge clk);
    endtask

    task automatic check_line(input string name, input int done_at, input int last_at);
        int bad = 0;
        int want_at = (exp_q.size() == 0) ? 1 : last_at + 1;
        check({name, " done seen"}, int'(done_at > 0), 1);
        check({name, " done timing"}, done_at, want_at);
        check({name, " plot count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y || got_q[i].c != exp_q[i].c) bad++;
        check({name, " pixel errors"}, bad, 0);
    endtask

    task automatic set_line(input int tx, input int ty, input int cx, input int cy);
        tower_x = 8'(tx); tower_y = 7'(ty); car_x = 8'(cx); car_y = 7'(cy);
    endtask

    initial begin
        rvec_t rt[8];
        int done_at, last_at, tx, ty, cx, cy, npulse, pulse_at, nplot;

        // Reset state.
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset plot", vga_plot, 0);
        check("reset drawn", drawn, 0);
        check("reset pulses", {draw_done, erase_done, delay_done, car_in_range}, 0);
        check("reset vga", {vga_x, vga_y, vga_colour}, 0);
        resetn = 1'b1;
        @(negedge clk);

        // Range table.
        rt[0] = '{80, 60, 85, 60, 1'b1, 1'b1};
        rt[1] = '{80, 60, 101, 60, 1'b1, 1'b0};
        rt[2] = '{80, 60, 100, 60, 1'b1, 1'b1};
        rt[3] = '{80, 60, 60, 40, 1'b1, 1'b1};
        rt[4] = '{80, 60, 59, 60, 1'b1, 1'b0};
        rt[5] = '{80, 60, 80, 81, 1'b1, 1'b0};
        rt[6] = '{80, 60, 85, 60, 1'b0, 1'b0};
        rt[7] = '{0, 0, 20, 20, 1'b1, 1'b1};
        foreach (rt[k]) begin
            set_line(rt[k].tx, rt[k].ty, rt[k].cx, rt[k].cy);
            car_valid = rt[k].v;
            @(negedge clk); @(negedge clk);
            check($sformatf("range table %0d", k), car_in_range, rt[k].exp);
        end

        // Random range vectors.
        for (int k = 0; k < 20; k++) begin
            tx = $urandom_range(30, 129); ty = $urandom_range(30, 89);
            cx = tx + $urandom_range(0, 60) - 30; cy = ty + $urandom_range(0, 60) - 30;
            set_line(tx, ty, cx, cy);
            car_valid = ($urandom_range(0, 4) != 0);
            @(negedge clk); @(negedge clk);
            check($sformatf("range rand %0d", k), car_in_range,
                  int'(car_valid && iabs(cx - tx) <= 20 && iabs(cy - ty) <= 20));
        end
        car_valid = 1'b0;

        // Main line (80,60)->(85,62) then its erase.
        set_line(80, 60, 85, 62);
        model_line(80, 60, 85, 62, 4);
        run_cmd(1'b0, 50, done_at, last_at);
        check_line("draw 80,60-85,62", done_at, last_at);
        check("draw6 count", got_q.size(), 6);
        if (got_q.size() == 6) begin
            check("draw6 first", got_q[0].x * 1000 + got_q[0].y, 80060);
            check("draw6 last", got_q[5].x * 1000 + got_q[5].y, 85062);
        end
        check("drawn after draw", drawn, 1);
        model_line(80, 60, 85, 62, 0);
        run_cmd(1'b1, 50, done_at, last_at);
        check_line("erase 80,60-85,62", done_at, last_at);
        check("drawn after erase", drawn, 0);

        // Car on tower: one pixel; second erase has nothing to clear.
        set_line(40, 30, 40, 30);
        model_line(40, 30, 40, 30, 4);
        run_cmd(1'b0, 20, done_at, last_at);
        check_line("draw single", done_at, last_at);
        model_line(40, 30, 40, 30, 0);
        run_cmd(1'b1, 20, done_at, last_at);
        check_line("erase single", done_at, last_at);
        exp_q.delete();
        run_cmd(1'b1, 20, done_at, last_at);
        check_line("erase undrawn", done_at, last_at);

        // Random lines, each drawn then erased.
        for (int k = 0; k < 8; k++) begin
            tx = $urandom_range(0, 159); ty = $urandom_range(0, 119);
            cx = $urandom_range(0, 159); cy = $urandom_range(0, 119);
            set_line(tx, ty, cx, cy);
            model_line(tx, ty, cx, cy, 4);
            run_cmd(1'b0, 400, done_at, last_at);
            check_line($sformatf("rand draw %0d", k), done_at, last_at);
            check($sformatf("rand len %0d", k), got_q.size(),
                  ((iabs(cx - tx) > iabs(cy - ty)) ? iabs(cx - tx) : iabs(cy - ty)) + 1);
            set_line($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 159), $urandom_range(0, 119));
            model_line(tx, ty, cx, cy, 0);
            run_cmd(1'b1, 400, done_at, last_at);
            check_line($sformatf("rand erase %0d", k), done_at, last_at);
        end

        // Delay held 10 cycles: one pulse on the 4th.
        npulse = 0; pulse_at = -1;
        delay = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (delay_done) begin npulse++; pulse_at = i; end
        end
        delay = 1'b0;
        check("delay pulses", npulse, 1);
        check("delay pulse cycle", pulse_at, 4);
        @(negedge clk);
        // Delay dropped after 2 cycles: no pulse.
        npulse = 0;
        delay = 1'b1;
        repeat (2) @(negedge clk);
        delay = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (delay_done) npulse++;
        end
        check("delay short pulses", npulse, 0);

        // Abort after 3 pixels: no done, drawn stays, erase replays the full latched line.
        set_line(80, 60, 100, 70);
        draw_laser = 1'b1;
        nplot = 0; npulse = 0;
        for (int i = 0; i < 40 && nplot < 3; i++) begin
            @(negedge clk);
            if (vga_plot) nplot++;
        end
        draw_laser = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (vga_plot) nplot++;
            if (draw_done) npulse++;
        end
        check("abort plots", nplot, 3);
        check("abort no done", npulse, 0);
        check("abort drawn", drawn, 1);
        set_line(10, 10, 11, 11);
        model_line(80, 60, 100, 70, 0);
        run_cmd(1'b1, 60, done_at, last_at);
        check_line("erase after abort", done_at, last_at);

        // Reset mid-line.
        set_line(20, 20, 60, 50);
        draw_laser = 1'b1;
        repeat (4) @(negedge clk);
        resetn = 1'b0; draw_laser = 1'b0;
        @(negedge clk);
        check("midreset plot", vga_plot, 0);
        check("midreset drawn", drawn, 0);
        check("midreset vga", {vga_x, vga_y, vga_colour}, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Disable mid-line: plotting stops and drawn clears.
        draw_laser = 1'b1;
        repeat (4) @(negedge clk);
        check("pre-disable drawn", drawn, 1);
        disabled = 1'b1;
        @(negedge clk);
        check("disabled plot", vga_plot, 0);
        check("disabled drawn", drawn, 0);
        @(negedge clk);
        check("disabled held plot", vga_plot, 0);
        disabled = 1'b0; draw_laser = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
